score_keeper: RTL



---
 rtl/score_pkg.sv | 20 ++
 rtl/btn_edge_sync.sv | 25 ++
 rtl/score_keeper.sv | 118 +++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and default parameters for the tennis/squash scoring engine.
package score_pkg;

  typedef enum logic [1:0] {
    S_PLAY       = 2'd0,
    S_GAME_WON   = 2'd1,
    S_MATCH_OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam int unsigned DEF_POINTS_TO_GAME = 3;
  localparam int unsigned DEF_GAMES_TO_MATCH = 3;
  localparam int unsigned DEF_SQUASH_MAX     = 7;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus delay flop; emits a one-cycle pulse per rising edge.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pt
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pt = s2 & ~s3;

endmodule

// File: rtl/score_keeper.sv
// Scoring engine: button pulses -> game points, games won / squash rallies, match result.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned POINTS_TO_GAME = DEF_POINTS_TO_GAME,
  parameter int unsigned GAMES_TO_MATCH = DEF_GAMES_TO_MATCH,
  parameter int unsigned SQUASH_MAX     = DEF_SQUASH_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic       squash_switch,
  input  logic       new_match,
  output logic [1:0] player1_score,
  output logic [1:0] player2_score,
  output logic [2:0] player1_match_score,
  output logic [2:0] player2_match_score,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam logic [1:0] PT_LAST  = 2'(POINTS_TO_GAME - 1);
  localparam logic [2:0] GM_WIN   = 3'(GAMES_TO_MATCH);
  localparam logic [2:0] SQ_LIMIT = 3'(SQUASH_MAX);

  logic   pt1, pt2;
  logic   sq_q;
  logic   gw;
  state_t state;
  logic   clear;
  logic [2:0] g1_inc, g2_inc;

  btn_edge_sync u_sync_p1 (.clk(clk), .rst(rst), .btn(btn_p1), .pt(pt1));
  btn_edge_sync u_sync_p2 (.clk(clk), .rst(rst), .btn(btn_p2), .pt(pt2));

  // A mode flip behaves exactly like a new_match pulse.
  assign clear  = new_match | (squash_switch ^ sq_q);
  assign g1_inc = player1_match_score + 3'd1;
  assign g2_inc = player2_match_score + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_q                <= 1'b0;
      state               <= S_PLAY;
      gw                  <= 1'b0;
      player1_score       <= '0;
      player2_score       <= '0;
      player1_match_score <= '0;
      player2_match_score <= '0;
      match_over          <= 1'b0;
      winner              <= WIN_NONE;
    end else begin
      sq_q <= squash_switch;
      if (clear) begin
        state               <= S_PLAY;
        gw                  <= 1'b0;
        player1_score       <= '0;
        player2_score       <= '0;
        player1_match_score <= '0;
        player2_match_score <= '0;
        match_over          <= 1'b0;
        winner              <= WIN_NONE;
      end else begin
        case (state)
          S_PLAY: begin
            // Simultaneous points cancel each other.
            if (pt1 ^ pt2) begin
              if (squash_switch) begin
                if (pt1 && player1_match_score != SQ_LIMIT)
                  player1_match_score <= g1_inc;
                if (pt2 && player2_match_score != SQ_LIMIT)
                  player2_match_score <= g2_inc;
              end else if (pt1) begin
                if (player1_score == PT_LAST) begin
                  state <= S_GAME_WON;
                  gw    <= 1'b0;
                end else begin
                  player1_score <= player1_score + 2'd1;
                end
              end else begin
                if (player2_score == PT_LAST) begin
                  state <= S_GAME_WON;
                  gw    <= 1'b1;
                end else begin
                  player2_score <= player2_score + 2'd1;
                end
              end
            end
          end
          S_GAME_WON: begin
            player1_score <= '0;
            player2_score <= '0;
            state         <= S_PLAY;
            if (!gw) begin
              player1_match_score <= g1_inc;
              if (g1_inc == GM_WIN) begin
                state      <= S_MATCH_OVER;
                winner     <= WIN_P1;
                match_over <= 1'b1;
              end
            end else begin
              player2_match_score <= g2_inc;
              if (g2_inc == GM_WIN) begin
                state      <= S_MATCH_OVER;
                winner     <= WIN_P2;
                match_over <= 1'b1;
              end
            end
          end
          S_MATCH_OVER: ;
          default: state <= S_PLAY;
        endcase
      end
    end
  end

endmodule
